// File: rtl/genius_pkg.sv
// rtl/genius_pkg.sv - shared key codes, NEC command codes and command-to-key mapping
package genius_pkg;

    typedef logic [2:0] key_t;

    localparam key_t KEY_GREEN  = 3'd0;
    localparam key_t KEY_RED    = 3'd1;
    localparam key_t KEY_YELLOW = 3'd2;
    localparam key_t KEY_BLUE   = 3'd3;
    localparam key_t KEY_START  = 3'd4;

    localparam logic [7:0] NEC_CMD_GREEN  = 8'h01;
    localparam logic [7:0] NEC_CMD_RED    = 8'h02;
    localparam logic [7:0] NEC_CMD_YELLOW = 8'h03;
    localparam logic [7:0] NEC_CMD_BLUE   = 8'h04;
    localparam logic [7:0] NEC_CMD_START  = 8'h12;

    localparam int KEY_FIFO_DEPTH = 4;

    typedef struct packed {
        logic hit;
        key_t key;
    } key_map_t;

    // Unknown commands return hit=0 so they are dropped without a frame error.
    function automatic key_map_t map_cmd(input logic [7:0] cmd);
        key_map_t m;
        m.hit = 1'b1;
        m.key = KEY_GREEN;
        case (cmd)
            NEC_CMD_GREEN:  m.key = KEY_GREEN;
            NEC_CMD_RED:    m.key = KEY_RED;
            NEC_CMD_YELLOW: m.key = KEY_YELLOW;
            NEC_CMD_BLUE:   m.key = KEY_BLUE;
            NEC_CMD_START:  m.key = KEY_START;
            default:        m.hit = 1'b0;
        endcase
        return m;
    endfunction

    function automatic int hold_cycles(input int clk_hz, input int hold_ms);
        longint prod;
        prod = longint'(clk_hz) * longint'(hold_ms);
        return int'((prod + 64'sd999) / 64'sd1000);
    endfunction

endpackage

// File: rtl/ir_key_queue_if.sv
// rtl/ir_key_queue_if.sv - IR frame input and key queue output bundle
interface ir_key_queue_if;

    logic [31:0]         ir_data;
    logic                ir_rdy;
    logic                key_pop;
    logic                key_valid;
    genius_pkg::key_t    key_code;
    logic                frame_err;
    logic                ovf;

    modport master (
        output ir_data,
        output ir_rdy,
        output key_pop,
        input  key_valid,
        input  key_code,
        input  frame_err,
        input  ovf
    );

    modport slave (
        input  ir_data,
        input  ir_rdy,
        input  key_pop,
        output key_valid,
        output key_code,
        output frame_err,
        output ovf
    );

endinterface

// File: rtl/key_fifo.sv
// rtl/key_fifo.sv - 4-entry key FIFO with 2-bit wrapping pointers and occupancy count
module key_fifo
    import genius_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  key_t din,
    output key_t dout,
    output logic full,
    output logic empty,
    output logic drop
);

    key_t       mem [KEY_FIFO_DEPTH];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic       do_push;
    logic       do_pop;

    assign full  = (count == 3'd4);
    assign empty = (count == 3'd0);

    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;

    assign dout = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
            for (int i = 0; i < KEY_FIFO_DEPTH; i++) begin
                mem[i] <= KEY_GREEN;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 2'd1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ir_key_queue.sv
// rtl/ir_key_queue.sv - NEC frame validation, key mapping, repeat suppression and key queue
module ir_key_queue
    import genius_pkg::*;
#(
    parameter int          CLK_HZ      = 50_000_000,
    parameter int          HOLD_MS     = 120,
    parameter logic [15:0] CUSTOM_CODE = 16'h6B86
) (
    input  logic           clk,
    input  logic           rst,
    ir_key_queue_if.slave  bus
);

    localparam int HOLD_CYC = hold_cycles(CLK_HZ, HOLD_MS);
    localparam int TW       = $clog2(HOLD_CYC + 1);

    logic [31:0]   s1_data;
    logic          s1_vld;
    logic [TW-1:0] hold_timer;
    key_t          last_key;
    logic          last_vld;
    logic          frame_err_q;
    logic          ovf_q;

    logic [15:0]   s1_custom;
    logic [7:0]    s1_cmd;
    logic [7:0]    s1_cmd_inv;
    logic          frame_ok;
    key_map_t      key_map;
    logic          mapped;
    logic          hold_run;
    logic          suppress;
    logic          accept;

    key_t          head_key;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_drop;

    assign s1_custom  = s1_data[15:0];
    assign s1_cmd     = s1_data[23:16];
    assign s1_cmd_inv = s1_data[31:24];

    assign frame_ok = (s1_custom == CUSTOM_CODE) && (s1_cmd == ~s1_cmd_inv);
    assign key_map  = map_cmd(s1_cmd);
    assign mapped   = s1_vld & frame_ok & key_map.hit;

    // Held-down remotes resend the same key; only a fresh press or a change gets through.
    assign hold_run = (hold_timer != '0);
    assign suppress = last_vld & hold_run & (key_map.key == last_key);
    assign accept   = mapped & ~suppress;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_data     <= 32'd0;
            s1_vld      <= 1'b0;
            hold_timer  <= '0;
            last_key    <= KEY_GREEN;
            last_vld    <= 1'b0;
            frame_err_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            s1_vld <= bus.ir_rdy;
            if (bus.ir_rdy) begin
                s1_data <= bus.ir_data;
            end

            frame_err_q <= s1_vld & ~frame_ok;
            ovf_q       <= fifo_drop;

            if (mapped) begin
                hold_timer <= TW'(HOLD_CYC);
            end else if (hold_run) begin
                hold_timer <= hold_timer - TW'(1);
            end

            // last_key tracks what the remote sent, even if the queue had no room for it.
            if (accept) begin
                last_key <= key_map.key;
                last_vld <= 1'b1;
            end
        end
    end

    key_fifo u_key_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (bus.key_pop),
        .din   (key_map.key),
        .dout  (head_key),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    assign bus.key_valid = ~fifo_empty;
    assign bus.key_code  = head_key;
    assign bus.frame_err = frame_err_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_ir_key_queue.sv
// tb/tb_ir_key_queue.sv - scoreboard bench for ir_key_queue
module tb_ir_key_queue;

    localparam int HOLD = 10;

    localparam logic [31:0] F_GREEN  = 32'hFE016B86;
    localparam logic [31:0] F_RED    = 32'hFD026B86;
    localparam logic [31:0] F_YELLOW = 32'hFC036B86;
    localparam logic [31:0] F_BLUE   = 32'hFB046B86;
    localparam logic [31:0] F_START  = 32'hED126B86;
    localparam logic [31:0] F_BADINV = 32'hFF016B86;
    localparam logic [31:0] F_BADCUS = 32'hFE011234;
    localparam logic [31:0] F_UNMAP  = 32'hAA556B86;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ir_key_queue_if bus ();

    ir_key_queue #(
        .CLK_HZ      (10_000),
        .HOLD_MS     (1),
        .CUSTOM_CODE (16'h6B86)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [2:0] sb[$];
    logic [2:0] m_last;
    bit         m_last_vld;
    int         m_start;
    int         m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_cnt      = 0;
        m_last     = 3'd0;
        m_last_vld = 1'b0;
        m_start    = 0;
    endtask

    // proc is the clock edge index at which the frame reaches the validation stage.
    task automatic model_frame(input logic [31:0] d, input int proc, output bit err, output bit ovf_e);
        logic [7:0] cmd;
        logic [2:0] key;
        bit         hit;
        bit         supp;
        cmd   = d[23:16];
        err   = (d[15:0] != 16'h6B86) || (cmd != ~d[31:24]);
        ovf_e = 1'b0;
        hit   = 1'b1;
        key   = 3'd0;
        case (cmd)
            8'h01:   key = 3'd0;
            8'h02:   key = 3'd1;
            8'h03:   key = 3'd2;
            8'h04:   key = 3'd3;
            8'h12:   key = 3'd4;
            default: hit = 1'b0;
        endcase
        if (!err && hit) begin
            supp    = m_last_vld && ((proc - m_start) <= HOLD) && (key == m_last);
            m_start = proc;
            if (!supp) begin
                m_last     = key;
                m_last_vld = 1'b1;
                if (m_cnt < 4) begin
                    sb.push_back(key);
                    m_cnt++;
                end else begin
                    ovf_e = 1'b1;
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [31:0] d, input bit pop_same);
        bit         err;
        bit         oe;
        int         cnt_orig;
        logic [2:0] exp_key;
        cnt_orig = m_cnt;
        if (pop_same) begin
            exp_key = (sb.size() > 0) ? sb.pop_front() : 3'd0;
            check("pop_same_valid", {31'd0, bus.key_valid}, 32'd1);
            check("pop_same_head", {29'd0, bus.key_code}, {29'd0, exp_key});
            if (m_cnt > 0) m_cnt--;
        end
        model_frame(d, cyc + 2, err, oe);
        bus.ir_data = d;
        bus.ir_rdy  = 1'b1;
        @(negedge clk);
        bus.ir_rdy  = 1'b0;
        bus.key_pop = pop_same;
        check("valid_lat1", {31'd0, bus.key_valid}, {31'd0, cnt_orig > 0});
        @(negedge clk);
        bus.key_pop = 1'b0;
        check("frame_err", {31'd0, bus.frame_err}, {31'd0, err});
        check("ovf", {31'd0, bus.ovf}, {31'd0, oe});
        check("valid_lat2", {31'd0, bus.key_valid}, {31'd0, m_cnt > 0});
        @(negedge clk);
        check("frame_err_end", {31'd0, bus.frame_err}, 32'd0);
        check("ovf_end", {31'd0, bus.ovf}, 32'd0);
    endtask

    task automatic pop_key();
        logic [2:0] exp_key;
        exp_key = sb.pop_front();
        check("pop_valid", {31'd0, bus.key_valid}, 32'd1);
        check("pop_code", {29'd0, bus.key_code}, {29'd0, exp_key});
        bus.key_pop = 1'b1;
        @(negedge clk);
        bus.key_pop = 1'b0;
        m_cnt--;
    endtask

    task automatic drain();
        while (sb.size() > 0) pop_key();
        check("drained_empty", {31'd0, bus.key_valid}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus.ir_data = 32'd0;
        bus.ir_rdy  = 1'b0;
        bus.key_pop = 1'b0;
        model_reset();
        rst = 1'b0;
        idle(3);
        check("rst_key_valid", {31'd0, bus.key_valid}, 32'd0);
        check("rst_key_code", {29'd0, bus.key_code}, 32'd0);
        check("rst_frame_err", {31'd0, bus.frame_err}, 32'd0);
        check("rst_ovf", {31'd0, bus.ovf}, 32'd0);
        rst = 1'b1;
        idle(1);

        // Single green key, then pop.
        send(F_GREEN, 1'b0);
        drain();

        // Rejected frames and an unmapped command.
        send(F_BADINV, 1'b0);
        send(F_BADCUS, 1'b0);
        send(F_UNMAP, 1'b0);
        bus.key_pop = 1'b1;
        idle(1);
        bus.key_pop = 1'b0;
        idle(1);
        check("pop_empty_valid", {31'd0, bus.key_valid}, 32'd0);

        // Repeat suppression: 5 cycles apart suppressed, 12 cycles later accepted.
        send(F_RED, 1'b0);
        idle(2);
        send(F_RED, 1'b0);
        idle(9);
        send(F_RED, 1'b0);
        check("hold_two_entries", sb.size(), 32'd2);
        drain();

        // Fill to four, fifth overflows, then push+pop at full.
        idle(12);
        send(F_GREEN, 1'b0);
        send(F_RED, 1'b0);
        send(F_YELLOW, 1'b0);
        send(F_BLUE, 1'b0);
        send(F_START, 1'b0);
        send(F_GREEN, 1'b1);
        drain();

        // Frames on consecutive cycles.
        begin
            bit e;
            bit o;
            model_frame(F_YELLOW, cyc + 2, e, o);
            bus.ir_data = F_YELLOW;
            bus.ir_rdy  = 1'b1;
            @(negedge clk);
            model_frame(F_BLUE, cyc + 2, e, o);
            bus.ir_data = F_BLUE;
            @(negedge clk);
            bus.ir_rdy = 1'b0;
            idle(2);
            check("b2b_count", sb.size(), 32'd2);
            drain();
        end

        // Reset with keys queued and hold running; same key afterwards is new.
        idle(12);
        send(F_GREEN, 1'b0);
        send(F_RED, 1'b0);
        send(F_YELLOW, 1'b0);
        rst = 1'b0;
        #1;
        check("midrst_valid", {31'd0, bus.key_valid}, 32'd0);
        check("midrst_code", {29'd0, bus.key_code}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        idle(1);
        send(F_YELLOW, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
